pipeline_hazard_ctrl: RTL

- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. MEM_WB_en connects directly to the MEM/WB latch cpu_en.
- Detects load-use hazards, squashes the fetched instruction on a taken branch (branch resolved in ID), and freezes the pipeline while data memory is not ready.
- Keeps saturating stall and flush counters, and raises a sticky error on a memory timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline.
// Resolves load-use hazards, squashes IF/ID on a taken branch, freezes the
// pipeline while data memory is busy, and flags a sticky memory timeout.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_en,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_register_write_address,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_en,
    output logic             ID_EX_flush,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             error
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              stall_inc, flush_inc, err_set;
    logic              do_run;
    logic              hazard, memstall;

    // Load-use hazard against a live (non-$0) destination, and a busy memory access.
    assign hazard = EX_MemRead && (EX_register_write_address != 5'd0) &&
                    ((ID_uses_rs && (ID_rs == EX_register_write_address)) ||
                     (ID_uses_rt && (ID_rt == EX_register_write_address)));
    assign memstall = mem_req && !mem_ready;

    // Next-state logic and zero-latency enable/flush decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next  = state;
        wait_next   = wait_cnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        err_set     = 1'b0;
        do_run      = 1'b0;
        pc_en       = 1'b0;
        IF_ID_en    = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_en    = 1'b0;
        ID_EX_flush = 1'b0;
        EX_MEM_en   = 1'b0;
        MEM_WB_en   = 1'b0;

        // Held reset or a cleared run enable keeps every latch frozen.
        if (reset && cpu_en) begin
            case (state)
                RUN: begin
                    if (memstall) begin
                        state_next = MEM_WAIT;
                        wait_next  = WAIT_W'(1);
                        stall_inc  = 1'b1;
                    end else begin
                        do_run = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_ready) begin
                        stall_inc = 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                            state_next = ERROR;
                            err_set    = 1'b1;
                        end else begin
                            wait_next = wait_cnt + 1'b1;
                        end
                    end else begin
                        // The ready cycle behaves like RUN minus the memory-stall rule.
                        state_next = RUN;
                        wait_next  = '0;
                        do_run     = 1'b1;
                    end
                end
                default: ; // ERROR: everything frozen until reset
            endcase

            if (do_run) begin
                if (hazard) begin
                    // Hold PC and IF/ID; a bubble enters EX. Any branch re-resolves after the stall.
                    ID_EX_en    = 1'b1;
                    ID_EX_flush = 1'b1;
                    EX_MEM_en   = 1'b1;
                    MEM_WB_en   = 1'b1;
                    stall_inc   = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    IF_ID_en    = 1'b1;
                    ID_EX_en    = 1'b1;
                    EX_MEM_en   = 1'b1;
                    MEM_WB_en   = 1'b1;
                    IF_ID_flush = branch_taken;
                    flush_inc   = branch_taken;
                end
            end
        end
    end

    // State, wait counter, saturating statistics and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            error       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_next;
            wait_cnt <= wait_next;
            if (stall_inc && (stall_count != '1)) stall_count <= stall_count + 1'b1;
            if (flush_inc && (flush_count != '1)) flush_count <= flush_count + 1'b1;
            if (err_set) error <= 1'b1;
        end
    end

endmodule
